// File: rtl/ft64_seq_multiplier.sv
// ft64_seq_multiplier
// Iterative WID x WID -> 2*WID integer multiplier. It retires DIGIT bits of
// the multiplicand magnitude per MULT cycle, so latency grows as WID/DIGIT.
// Signed modes multiply magnitudes and fix the sign in a final SGNADJ cycle.
//
// Handshake: the issuer pulses ld while idle=1. The operands and mode are
// captured on that edge. done is high in DONE, and also in IDLE whenever ld is
// low. It therefore drops in the load cycle, which keeps a stale o from being
// consumed. abort returns the unit to IDLE from any state without writing o.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   ld           start request (honoured only in IDLE)
//   abort        cancel the operation in flight (highest priority)
//   sgn, sgnus   signed x signed / signed x unsigned mode (sgnus wins)
//   a, b         multiplicand / multiplier, WID bits
//   o            registered 2*WID-bit product
//   done, idle   status (combinational from state and ld)
//   dbg_state_o  current FSM state encoding, for observation
module ft64_seq_multiplier #(
  parameter int WID   = 64,
  parameter int DIGIT = 16,
  parameter int CNTW  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             abort,
  input  logic             sgn,
  input  logic             sgnus,
  input  logic [WID-1:0]   a,
  input  logic [WID-1:0]   b,
  output logic [2*WID-1:0] o,
  output logic             done,
  output logic             idle,
  output logic [1:0]       dbg_state_o
);

  localparam int NDIG = WID / DIGIT;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MULT   = 2'd1,
    S_SGNADJ = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WID-1:0]   aa_q, aa_d;
  logic [WID-1:0]   bb_q, bb_d;
  logic [2*WID-1:0] prod_q, prod_d;
  logic [2*WID-1:0] o_q, o_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             so_q, so_d;

  logic [WID-1:0]       a_mag, b_mag;
  logic [WID+DIGIT-1:0] p;
  logic [2*WID-1:0]     prod_step;

  // Two's-complement magnitude. The most negative value maps to 2^(WID-1),
  // which is still representable as an unsigned WID-bit number.
  assign a_mag = a[WID-1] ? -a : a;
  assign b_mag = b[WID-1] ? -b : b;

  // One digit step: partial product plus the upper half of the accumulator.
  // It cannot overflow WID+DIGIT bits.
  assign p = (WID+DIGIT)'(bb_q) * (WID+DIGIT)'(aa_q[DIGIT-1:0])
           + (WID+DIGIT)'(prod_q[2*WID-1:WID]);

  // {p, prod[WID-1:DIGIT]}, written so that it stays legal when DIGIT == WID.
  // The bits dropped by the cast are the zeros that the shift brings in.
  assign prod_step = (2*WID)'({p, prod_q[WID-1:0]} >> DIGIT);

  always_comb begin
    state_d = state_q;
    aa_d    = aa_q;
    bb_d    = bb_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    so_d    = so_q;
    o_d     = o_q;
    case (state_q)
      S_IDLE: begin
        if (ld && !abort) begin
          if (sgnus) begin
            aa_d = a_mag;
            bb_d = b;
            so_d = a[WID-1];
          end else if (sgn) begin
            aa_d = a_mag;
            bb_d = b_mag;
            so_d = a[WID-1] ^ b[WID-1];
          end else begin
            aa_d = a;
            bb_d = b;
            so_d = 1'b0;
          end
          prod_d  = '0;
          cnt_d   = CNTW'(NDIG);
          state_d = S_MULT;
        end
      end
      S_MULT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          prod_d = prod_step;
          aa_d   = aa_q >> DIGIT;
          cnt_d  = cnt_q - CNTW'(1);
        end else begin
          state_d = S_SGNADJ;
        end
      end
      S_SGNADJ: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          o_d     = so_q ? -prod_q : prod_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // o is already written here, so abort changes nothing and ld is ignored.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      aa_q    <= '0;
      bb_q    <= '0;
      prod_q  <= '0;
      o_q     <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      aa_q    <= aa_d;
      bb_q    <= bb_d;
      prod_q  <= prod_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
    end
  end

  assign o           = o_q;
  assign idle        = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE) || ((state_q == S_IDLE) && !ld);
  assign dbg_state_o = state_q;

endmodule
